// File: rtl/image_brightness_stage.sv
// image_brightness_stage: 2-stage saturating brightness adjust over one frame; BRIGHTNESS_GRAY_EN selects luma mode
module image_brightness_stage #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int VALUE  = 100,
  parameter int SIGN   = 1
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
  output logic       hsync,
  output logic [7:0] DATA_WRITE_R,
  output logic [7:0] DATA_WRITE_G,
  output logic [7:0] DATA_WRITE_B,
  output logic       busy,
  output logic       frame_done
);
  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int CW = $clog2(TOTAL + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic acc, last, v1;
  logic [7:0] r1, g1, b1;
  logic [7:0] p_r, p_g, p_b;
  function automatic logic [7:0] adj(input logic [7:0] x);
    logic [8:0] s;
    s = (SIGN != 0) ? {1'b0, x} + 9'(VALUE) : {1'b0, x} - 9'(VALUE);
    return s[8] ? ((SIGN != 0) ? 8'hff : 8'h00) : s[7:0];
  endfunction
`ifdef BRIGHTNESS_GRAY_EN
  logic [7:0] y;
  assign y = 8'((10'(in_R) + {1'b0, in_G, 1'b0} + 10'(in_B)) >> 2);
  assign p_r = y;
  assign p_g = y;
  assign p_b = y;
`else
  assign p_r = in_R;
  assign p_g = in_G;
  assign p_b = in_B;
`endif
  always_comb begin
    acc = (state == RUN) && in_valid;
    last = acc && (cnt == CW'(TOTAL - 1));
    state_nx = state == IDLE  ? (start ? RUN : IDLE) :
               state == RUN   ? (last ? DRAIN : RUN) :
               state == DRAIN ? (v1 ? DRAIN : DONE) : IDLE;
    busy = (state == RUN) || (state == DRAIN);
    frame_done = state == DONE;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt <= '0;
      v1 <= 1'b0;
      r1 <= '0;
      g1 <= '0;
      b1 <= '0;
      hsync <= 1'b0;
      DATA_WRITE_R <= '0;
      DATA_WRITE_G <= '0;
      DATA_WRITE_B <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) cnt <= '0;
      else if (acc) cnt <= cnt + 1'b1;
      v1 <= acc;
      if (acc) begin
        r1 <= p_r;
        g1 <= p_g;
        b1 <= p_b;
      end
      hsync <= v1;
      if (v1) begin
        DATA_WRITE_R <= adj(r1);
        DATA_WRITE_G <= adj(g1);
        DATA_WRITE_B <= adj(b1);
      end
    end
  end
endmodule

// File: tb/tb_image_brightness_stage.sv
// tb_image_brightness_stage: randomized frames against a cycle-level arithmetic reference, add and subtract instances
module tb_image_brightness_stage;
  localparam int TOTAL = 8;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic [7:0] r = '0, g = '0, b = '0;
  logic hs_a, bz_a, fd_a, hs_s, bz_s, fd_s;
  logic [7:0] ar, ag, ab, sr, sg, sb;
  int checks = 0, errors = 0;
  int t = 0, last_t = -100, cnt = 0;
  bit run = 0, v1 = 0, v2 = 0;
  logic [23:0] d1 = '0, d2 = '0, ea = '0, es = '0;

  always #5 clk = ~clk;

  image_brightness_stage #(.WIDTH(4), .HEIGHT(2), .VALUE(100), .SIGN(1)) u_add (
    .HCLK(clk), .HRESETn(rst_n), .start(start), .in_valid(in_valid),
    .in_R(r), .in_G(g), .in_B(b), .hsync(hs_a),
    .DATA_WRITE_R(ar), .DATA_WRITE_G(ag), .DATA_WRITE_B(ab),
    .busy(bz_a), .frame_done(fd_a));
  image_brightness_stage #(.WIDTH(4), .HEIGHT(2), .VALUE(100), .SIGN(0)) u_sub (
    .HCLK(clk), .HRESETn(rst_n), .start(start), .in_valid(in_valid),
    .in_R(r), .in_G(g), .in_B(b), .hsync(hs_s),
    .DATA_WRITE_R(sr), .DATA_WRITE_G(sg), .DATA_WRITE_B(sb),
    .busy(bz_s), .frame_done(fd_s));

  function automatic int fa(input int x);
    return (x + 100 > 255) ? 255 : x + 100;
  endfunction
  function automatic int fs(input int x);
    return (x < 100) ? 0 : x - 100;
  endfunction
  function automatic logic [23:0] model(input logic [23:0] p, input bit add);
    int c0, c1, c2;
    c0 = int'(p[23:16]);
    c1 = int'(p[15:8]);
    c2 = int'(p[7:0]);
`ifdef BRIGHTNESS_GRAY_EN
    c0 = (c0 + 2 * c1 + c2) / 4;
    c1 = c0;
    c2 = c0;
`endif
    c0 = add ? fa(c0) : fs(c0);
    c1 = add ? fa(c1) : fs(c1);
    c2 = add ? fa(c2) : fs(c2);
    return {c0[7:0], c1[7:0], c2[7:0]};
  endfunction
  function automatic logic [23:0] rnd();
    return 24'($urandom);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_all();
    bit busy_exp, done_exp;
    busy_exp = run || (t > last_t && t <= last_t + 2);
    done_exp = (t == last_t + 3);
    chk("hsync_add", 32'(hs_a), 32'(v2));
    chk("hsync_sub", 32'(hs_s), 32'(v2));
    chk("busy_add", 32'(bz_a), 32'(busy_exp));
    chk("busy_sub", 32'(bz_s), 32'(busy_exp));
    chk("done_add", 32'(fd_a), 32'(done_exp));
    chk("done_sub", 32'(fd_s), 32'(done_exp));
    chk("data_add", 32'({ar, ag, ab}), 32'(ea));
    chk("data_sub", 32'({sr, sg, sb}), 32'(es));
  endtask

  task automatic tick(input bit st, input bit v, input logic [23:0] p);
    bit acc;
    start = st;
    in_valid = v;
    {r, g, b} = p;
    acc = run && v;
    v2 = v1;
    d2 = d1;
    v1 = acc;
    d1 = p;
    if (acc) begin
      cnt++;
      if (cnt == TOTAL) begin
        run = 0;
        last_t = t;
      end
    end else if (st && !run && t >= last_t + 4) begin
      run = 1;
      cnt = 0;
    end
    @(posedge clk);
    #1;
    t++;
    if (v2) begin
      ea = model(d2, 1);
      es = model(d2, 0);
    end
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    #2;
    run = 0;
    cnt = 0;
    v1 = 0;
    v2 = 0;
    ea = '0;
    es = '0;
    last_t = -100;
    check_all();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic finish_frame();
    for (int i = 0; i < 200 && run; i++) tick(1'($urandom_range(0, 1)), ($urandom % 3) != 0, rnd());
    repeat (5) tick(0, 0, rnd());
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    repeat (3) tick(0, 1, rnd());
    tick(1, 1, {8'd10, 8'd200, 8'd155});
    repeat (8) tick(0, 1, {8'd10, 8'd200, 8'd155});
    repeat (5) tick(0, 0, rnd());
    tick(1, 0, rnd());
    tick(0, 1, {8'd99, 8'd100, 8'd101});
    tick(0, 0, rnd());
    tick(0, 0, rnd());
    tick(0, 1, {8'd40, 8'd80, 8'd120});
    tick(1, 1, rnd());
    finish_frame();
    tick(1, 0, rnd());
    repeat (3) tick(0, 1, rnd());
    do_reset();
    repeat (6) tick(0, 0, rnd());
    tick(0, 1, rnd());
    tick(1, 0, rnd());
    finish_frame();
    for (int f = 0; f < 4; f++) begin
      tick(1, 1'($urandom_range(0, 1)), rnd());
      finish_frame();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
